// File: rtl/hdc_sched_cmd_if.sv
// Host command channel for hdc_op_scheduler.
// Valid/ready handshake carrying {op, addr_a, addr_b}.
interface hdc_sched_cmd_if #(
  parameter int ADDR_W = 21
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr_a;
  logic [ADDR_W-1:0] cmd_addr_b;

  modport master (
    output cmd_valid, cmd_op,
    output cmd_addr_a, cmd_addr_b,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op,
    input  cmd_addr_a, cmd_addr_b,
    output cmd_ready
  );
endinterface

// File: rtl/hdc_op_scheduler.sv
// HDC kernel command scheduler: FIFO + one-at-a-time issue, RAM arbitration.
// Optional WAIT watchdog enabled by defining HDC_SCHED_TIMEOUT_EN.
module hdc_op_scheduler #(
  parameter int NUM_ENGINES    = 2,
  parameter int FIFO_DEPTH     = 4,
  parameter int ADDR_W         = 21,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk,
  input  logic                          reset_n,
  hdc_sched_cmd_if.slave                cmd,
  input  logic                          clr_err,
  output logic [NUM_ENGINES-1:0]        eng_valid,
  output logic [ADDR_W-1:0]             eng_addr_a,
  output logic [ADDR_W-1:0]             eng_addr_b,
  input  logic [NUM_ENGINES-1:0]        eng_done,
  input  logic [NUM_ENGINES-1:0]        eng_we_n,
  input  logic [NUM_ENGINES*ADDR_W-1:0] eng_waddress,
  input  logic [NUM_ENGINES*DATA_W-1:0] eng_data_wr,
  input  logic [NUM_ENGINES*ADDR_W-1:0] eng_raddress,
  output logic                          we_n,
  output logic [ADDR_W-1:0]             waddress,
  output logic [DATA_W-1:0]             data_wr,
  output logic [ADDR_W-1:0]             raddress,
  output logic                          busy,
  output logic [15:0]                   op_count,
  output logic                          err_bad_op,
  output logic                          err_timeout
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t state;

  logic [3:0]        op_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] a_mem  [FIFO_DEPTH];
  logic [ADDR_W-1:0] b_mem  [FIFO_DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic [3:0]             cur_op;
  logic                   push;
  logic                   pop;
  logic                   empty;
  logic                   full;
  logic                   op_ok;
  logic                   done_sel;
  logic [NUM_ENGINES-1:0] start_vec;

  assign full          = (count == CW'(FIFO_DEPTH));
  assign empty         = (count == '0);
  assign cmd.cmd_ready = !full;
  assign push          = cmd.cmd_valid && !full;
  assign pop           = !empty &&
                         (state == S_IDLE ||
                          state == S_DRAIN);
  assign op_ok         = ({1'b0, cur_op} <
                          5'(NUM_ENGINES));
  assign busy          = (state != S_IDLE) || !empty;

  // Command storage; contents need no reset
  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr] <= cmd.cmd_op;
      a_mem[wr_ptr]  <= cmd.cmd_addr_a;
      b_mem[wr_ptr]  <= cmd.cmd_addr_b;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // One-hot start vector for the head command
  always_comb begin
    start_vec = '0;
    for (int k = 0; k < NUM_ENGINES; k++)
      start_vec[k] = (op_mem[rd_ptr] == 4'(k));
  end

  // RAM bus and done belong to the running kernel in WAIT
  always_comb begin
    we_n     = 1'b1;
    waddress = '0;
    data_wr  = '0;
    raddress = '0;
    done_sel = 1'b0;
    for (int k = 0; k < NUM_ENGINES; k++) begin
      if (state == S_WAIT && cur_op == 4'(k)) begin
        we_n     = eng_we_n[k];
        waddress = eng_waddress[k*ADDR_W +: ADDR_W];
        data_wr  = eng_data_wr[k*DATA_W +: DATA_W];
        raddress = eng_raddress[k*ADDR_W +: ADDR_W];
        done_sel = eng_done[k];
      end
    end
  end

`ifdef HDC_SCHED_TIMEOUT_EN
  logic [31:0] wd_cnt;
`else
  // No watchdog: flag is constant low for any legal limit
  assign err_timeout = (TIMEOUT_CYCLES < 0);
`endif

  // Issue FSM, start pulse, counters and sticky errors
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      cur_op      <= '0;
      eng_valid   <= '0;
      eng_addr_a  <= '0;
      eng_addr_b  <= '0;
      op_count    <= '0;
      err_bad_op  <= 1'b0;
`ifdef HDC_SCHED_TIMEOUT_EN
      err_timeout <= 1'b0;
      wd_cnt      <= '0;
`endif
    end else begin
      eng_valid <= '0;
      if (clr_err) begin
        err_bad_op  <= 1'b0;
`ifdef HDC_SCHED_TIMEOUT_EN
        err_timeout <= 1'b0;
`endif
      end
      unique case (state)
        S_IDLE, S_DRAIN: begin
          if (pop) begin
            cur_op     <= op_mem[rd_ptr];
            eng_addr_a <= a_mem[rd_ptr];
            eng_addr_b <= b_mem[rd_ptr];
            eng_valid  <= start_vec;
            state      <= S_ISSUE;
          end else begin
            state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          if (op_ok) begin
            state <= S_WAIT;
`ifdef HDC_SCHED_TIMEOUT_EN
            wd_cnt <= '0;
`endif
          end else begin
            err_bad_op <= 1'b1;
            state      <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (done_sel) begin
            op_count <= op_count + 16'd1;
            state    <= S_DRAIN;
          end
`ifdef HDC_SCHED_TIMEOUT_EN
          else if (wd_cnt ==
                   32'(TIMEOUT_CYCLES - 1)) begin
            err_timeout <= 1'b1;
            state       <= S_DRAIN;
          end else begin
            wd_cnt <= wd_cnt + 32'd1;
          end
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
